acc_feeder: RTL

- Upstream sequencer for the accumulator core.
- On a start command it reads N operands from a 1-cycle-latency buffer RAM and streams them into the core as run/valid/number beats.
- It counts the core's per-beat valid responses, captures the core's running result, and reports the sum for this job only: final result minus the result snapshotted at start.
- It then pulses done and returns to idle.

---
 rtl/acc_pkg.sv | 15 +
 rtl/acc_feeder.sv | 130 +++++++++++++
 2 files changed

// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator core and its feeder.
// Width defaults here must track the core's number/result ports.
package acc_pkg;

    localparam int ACC_IN_DATA_WIDTH = 8;
    localparam int ACC_DWIDTH        = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/acc_feeder.sv
// Job sequencer: streams N buffer-RAM operands into the accumulator core
// and reports the core's result delta over the job.
module acc_feeder
    import acc_pkg::*;
#(
    parameter int IN_DATA_WIDTH = ACC_IN_DATA_WIDTH,
    parameter int DWIDTH        = ACC_DWIDTH,
    parameter int AWIDTH        = 8,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [CNT_WIDTH-1:0]     num_i,
    input  logic [AWIDTH-1:0]        base_addr_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [DWIDTH-1:0]        sum_o,
    output logic                     mem_rd_en_o,
    output logic [AWIDTH-1:0]        mem_addr_o,
    input  logic [IN_DATA_WIDTH-1:0] mem_rdata_i,
    output logic                     acc_run_o,
    output logic                     acc_valid_o,
    output logic [IN_DATA_WIDTH-1:0] acc_number_o,
    input  logic                     acc_valid_i,
    input  logic [DWIDTH-1:0]        acc_result_i
);

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   num_q, num_d;
    logic [CNT_WIDTH-1:0]   issue_cnt_q, issue_cnt_d;
    logic [CNT_WIDTH-1:0]   ret_cnt_q, ret_cnt_d;
    logic [AWIDTH-1:0]      base_addr_q, base_addr_d;
    logic [DWIDTH-1:0]      base_sum_q, base_sum_d;
    logic [DWIDTH-1:0]      sum_q, sum_d;
    logic                   valid_q, valid_d;
    logic                   rd_en;
    logic                   last_issue;
    logic                   last_ret;

    assign rd_en      = (state_q == ST_FETCH);
    assign last_issue = (issue_cnt_q == num_q - CNT_WIDTH'(1));
    assign last_ret   = (ret_cnt_q == num_q - CNT_WIDTH'(1));

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        base_addr_d = base_addr_q;
        base_sum_d  = base_sum_q;
        sum_d       = sum_q;
        // Operands are never stalled, so valid is just the strobe delayed.
        valid_d     = rd_en;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (num_i != '0) begin
                        num_d       = num_i;
                        base_addr_d = base_addr_i;
                        base_sum_d  = acc_result_i;
                        issue_cnt_d = '0;
                        ret_cnt_d   = '0;
                        state_d     = ST_FETCH;
                    end else begin
                        sum_d   = '0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_FETCH: begin
                issue_cnt_d = issue_cnt_q + CNT_WIDTH'(1);
                if (acc_valid_i) begin
                    ret_cnt_d = ret_cnt_q + CNT_WIDTH'(1);
                end
                if (last_issue) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (acc_valid_i) begin
                    ret_cnt_d = ret_cnt_q + CNT_WIDTH'(1);
                    if (last_ret) begin
                        sum_d   = acc_result_i - base_sum_q;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            num_q       <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            base_addr_q <= '0;
            base_sum_q  <= '0;
            sum_q       <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            base_addr_q <= base_addr_d;
            base_sum_q  <= base_sum_d;
            sum_q       <= sum_d;
            valid_q     <= valid_d;
        end
    end

    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_DONE);
    assign sum_o        = sum_q;
    assign mem_rd_en_o  = rd_en;
    assign mem_addr_o   = rd_en ? base_addr_q + AWIDTH'(issue_cnt_q) : '0;
    assign acc_run_o    = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign acc_valid_o  = valid_q;
    assign acc_number_o = mem_rdata_i;

endmodule
